bus_req_order_queue: RTL
========================

// Module: bus_req_order_queue
// PURPOSE
//  Records the arrival order of bus requesters for the common-bus arbiter. Each cycle it detects new requests
//  on NUM_REQ lines and enqueues the requester ID (index+1, 0 = none), then presents IDs oldest-first
//  to the grant logic over a valid/ready pop port. Parametrised successor of the 8-line order FIFO:
//  fully synchronous, configurable depth, requester count and edge/level capture mode, plus loss reporting.
// PARAMETERS
//  NUM_REQ    8  number of requester lines
//  DEPTH      8  queue entries; power of 2, >=2
//  ID_W       4  ID width; 2**ID_W > NUM_REQ required
//  LEVEL_MODE 0  0 = enqueue on request rising edge; 1 = enqueue while request high and ID not already queued
// PORTS
//  clk          in   1                  clock, all state updates on rising edge
//  rst          in   1                  reset, asynchronous, active-high
//  req_i        in   NUM_REQ            request lines, bit i = requester ID i+1
//  deq_ready_i  in   1                  consumer accepts head entry this cycle
//  deq_valid_o  out  1                  queue non-empty; deq_id_o valid
//  deq_id_o     out  ID_W               head ID (show-ahead); 0 when empty
//  count_o      out  $clog2(DEPTH)+1    entries stored, 0..DEPTH
//  full_o       out  1                  count_o == DEPTH
//  empty_o      out  1                  count_o == 0
//  lost_o       out  1                  sticky: a request event was dropped
//  clr_lost_i   in   1                  synchronous clear of lost_o
// BEHAVIOUR
//  Reset (async): rd/wr ptrs, count, prev_req, pending, queued, lost all 0 -> deq_valid_o=0, deq_id_o=0,
//   count_o=0, empty_o=1, full_o=0, lost_o=0. Memory contents not reset. Reset mid-operation discards all.
//  Edge mode: edge[i] = req_i[i] & ~prev_req[i]; prev_req <= req_i every cycle. cand = pending | edge.
//  Level mode: cand = req_i & ~queued; pending and prev_req unused (held 0).
//  Write: at most one enqueue per cycle; winner = lowest set index of cand (fixed priority, ID 1 highest).
//   Write allowed when count<DEPTH, or count==DEPTH and a pop occurs the same cycle.
//   Winner written at this edge: mem[wr_ptr] <= winner+1, wr_ptr++ (wraps mod DEPTH).
//  Edge mode pending: pending[i] <= cand[i] & ~(written this cycle for i). Non-winners wait in pending.
//   Loss: edge[i] while pending[i] already 1 (from an earlier cycle) -> lost_o <= 1; pending stays 1.
//  Level mode queued: queued[i] set when ID i+1 written; cleared when ID i+1 popped. Requires
//   DEPTH >= NUM_REQ (one slot per requester), so no loss; lost_o never set in level mode.
//  Pop: when deq_valid_o & deq_ready_i: rd_ptr++ (wraps). deq_ready_i with empty queue ignored.
//  Count: +1 write only, -1 pop only, unchanged on write+pop or neither. Never exceeds DEPTH or underflows.
//  Latency: request edge sampled at clk edge t with free slot and winning priority -> deq_valid_o=1 and
//   deq_id_o=ID after edge t (1 cycle). Pop at edge t exposes next entry after edge t.
//  deq_id_o = mem[rd_ptr] when non-empty, else 0 (combinational from regs).
//  clr_lost_i: lost_o <= 0 unless a loss occurs the same cycle (set wins).
//  Full with no pop: edge-mode requests accumulate in pending; level-mode requests simply wait.
// TESTING
//  1 Reset: assert rst async mid-cycle with 3 entries -> count_o=0, empty_o=1, deq_id_o=0 immediately.
//  2 Edge mode: req_i rises bits 2,0,5 same cycle, deq_ready_i=0 -> over 3 cycles queue holds 1,3,6;
//    count_o=3; then pop each cycle -> deq_id_o 1,3,6, then empty_o=1.
//  3 Full/wrap (DEPTH=8): 8 single edges fill (full_o=1); 9th edge pends; pop+write same cycle -> count_o
//    stays 8; drain 16 total entries across wrap -> order preserved, IDs match arrival.
//  4 Loss: fill queue, pulse req_i[3] twice while full -> lost_o=1 sticky; clr_lost_i -> 0; ID 4 appears once.
//  5 Level mode: hold req_i[1] high 20 cycles -> ID 2 queued once; pop it while still high -> re-queued
//    next cycle; deassert -> no further entries.
//  6 Empty pop: deq_ready_i=1 with empty queue -> count_o stays 0, no pointer movement, deq_id_o=0.

Source files
------------

// File: rtl/bus_req_order_queue.sv
// Arrival-order queue for bus requesters: captures new requests (edge or level),
// enqueues requester IDs one per cycle by fixed priority, and pops oldest-first.
module bus_req_order_queue #(
  parameter int unsigned NUM_REQ    = 8,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned ID_W       = 4,
  parameter int unsigned LEVEL_MODE = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_i,
  input  logic                     deq_ready_i,
  output logic                     deq_valid_o,
  output logic [ID_W-1:0]          deq_id_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic                     lost_o,
  input  logic                     clr_lost_i
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [NUM_REQ-1:0] prev_req_q, prev_req_d;
  logic [NUM_REQ-1:0] pending_q, pending_d;
  logic [NUM_REQ-1:0] queued_q, queued_d;
  logic               lost_q, lost_d;
  logic [ID_W-1:0]    mem_q [DEPTH];

  logic [NUM_REQ-1:0] rise, cand, win_oh, pop_oh;
  logic [ID_W-1:0]    win_id, head_id;
  logic               found, pop, wr_en, loss;

  // Capture, fixed-priority winner selection and next-state computation
  always_comb begin
    rise       = req_i & ~prev_req_q;
    cand       = (LEVEL_MODE != 0) ? (req_i & ~queued_q) : (pending_q | rise);
    pop        = (count_q != '0) && deq_ready_i;
    head_id    = mem_q[rd_ptr_q];
    win_oh     = '0;
    win_id     = '0;
    found      = 1'b0;
    pop_oh     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (cand[i] && !found) begin
        win_oh[i] = 1'b1;
        win_id    = ID_W'(i + 1);
        found     = 1'b1;
      end
      pop_oh[i] = pop && (head_id == ID_W'(i + 1));
    end
    wr_en      = found && ((count_q < CNT_W'(DEPTH)) || pop);
    loss       = (LEVEL_MODE == 0) && ((rise & pending_q) != '0);

    wr_ptr_d   = wr_en ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
    rd_ptr_d   = pop ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
    count_d    = count_q;
    if (wr_en && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!wr_en && pop) begin
      count_d = count_q - CNT_W'(1);
    end

    prev_req_d = '0;
    pending_d  = '0;
    queued_d   = '0;
    if (LEVEL_MODE != 0) begin
      queued_d = (queued_q & ~pop_oh) | (wr_en ? win_oh : '0);
    end else begin
      prev_req_d = req_i;
      pending_d  = cand & ~(wr_en ? win_oh : '0);
    end

    // A new loss wins over a clear in the same cycle
    lost_d = loss ? 1'b1 : (clr_lost_i ? 1'b0 : lost_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      prev_req_q <= '0;
      pending_q  <= '0;
      queued_q   <= '0;
      lost_q     <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      prev_req_q <= prev_req_d;
      pending_q  <= pending_d;
      queued_q   <= queued_d;
      lost_q     <= lost_d;
    end
  end

  // Storage is not reset; validity is tracked by count_q
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= win_id;
    end
  end

  assign deq_valid_o = (count_q != '0);
  assign deq_id_o    = (count_q != '0) ? head_id : '0;
  assign count_o     = count_q;
  assign full_o      = (count_q == CNT_W'(DEPTH));
  assign empty_o     = (count_q == '0);
  assign lost_o      = lost_q;

endmodule
